// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: operand bypass selects and load-use stall control for an in-order pipeline
module hazard_forward_ctrl #(
   parameter int REG_BITS   = 5,
   parameter int NUM_SRC    = 2,
   parameter int FWD_STAGES = 2,
   parameter int LOAD_LAT   = 1,
   parameter int CNT_BITS   = 16,
   localparam int SEL_BITS  = $clog2(FWD_STAGES + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         id_valid_i,
   input  logic [NUM_SRC*REG_BITS-1:0]  id_src_i,
   input  logic [NUM_SRC-1:0]           id_src_used_i,
   input  logic [REG_BITS-1:0]          id_dest_i,
   input  logic                         id_wen_i,
   input  logic                         id_is_load_i,
   input  logic                         flush_i,
   input  logic                         freeze_i,
   output logic                         stall_o,
   output logic [NUM_SRC*SEL_BITS-1:0]  ex_fwd_sel_o,
   output logic                         ex_valid_o,
   output logic [CNT_BITS-1:0]          stall_cycles_o
);
   typedef struct packed {
      logic                v;
      logic                w;
      logic                l;
      logic [REG_BITS-1:0] d;
   } ent_t;
   ent_t [FWD_STAGES-1:0] s_q, s_d;
   logic [NUM_SRC-1:0][SEL_BITS-1:0] op_sel;
   logic [NUM_SRC-1:0] op_haz;
   logic [NUM_SRC*SEL_BITS-1:0] sel_q, sel_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic accept;
   // scan from oldest to youngest so the nearest matching producer overrides
   always_comb begin
      op_sel = '0;
      op_haz = '0;
      for (int i = 0; i < NUM_SRC; i++)
         for (int j = FWD_STAGES - 1; j >= 0; j--)
            if (id_src_used_i[i] && s_q[j].v && s_q[j].w && s_q[j].d != '0 &&
                s_q[j].d == id_src_i[i*REG_BITS +: REG_BITS]) begin
               op_haz[i] = s_q[j].l && (j < LOAD_LAT);
               op_sel[i] = op_haz[i] ? '0 : SEL_BITS'(j + 1);
            end
   end
   assign stall_o = id_valid_i & ~flush_i & (|op_haz);
   assign accept  = id_valid_i & ~flush_i & ~stall_o;
   // next shadow pipeline, selects and saturating stall counter
   always_comb begin
      s_d[0] = accept ? ent_t'{v: 1'b1, w: id_wen_i, l: id_is_load_i, d: id_dest_i} : '0;
      for (int j = 1; j < FWD_STAGES; j++) s_d[j] = s_q[j-1];
      sel_d = accept ? op_sel : '0;
      cnt_d = (stall_o && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   end
   // state advances only while the pipeline is not frozen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q   <= '0;
         sel_q <= '0;
         cnt_q <= '0;
      end else if (!freeze_i) begin
         s_q   <= s_d;
         sel_q <= sel_d;
         cnt_q <= cnt_d;
      end
   end
   assign ex_valid_o     = s_q[0].v;
   assign ex_fwd_sel_o   = sel_q;
   assign stall_cycles_o = cnt_q;
endmodule
